// File: rtl/regfile_scoreboard_if.sv
// Bundle of decode-side read/issue signals and the WB write-back/flush path
// for the ID-stage register file with a pending-write scoreboard.
//
// Handshake: an issue completes on a rising edge where iss_valid && iss_ready
// (with iss_dest < NUM_REGS). iss_ready is combinational from iss_dest and the
// scoreboard state, so decode must hold iss_valid/iss_dest stable while it is
// low. Write-back and flush are single-cycle strobes with no back-pressure.
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int RD_PORTS = 2
);
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS-1:0]        rd_en;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_pending;
    logic                       hazard;
    logic                       iss_valid;
    logic [ADDR_W-1:0]          iss_dest;
    logic                       iss_ready;
    logic                       wb_en;
    logic [ADDR_W-1:0]          wb_dest;
    logic [DATA_W-1:0]          wb_data;
    logic                       flush;
    logic                       sb_busy;

    // Decode / WB / branch side
    modport master (
        output rd_addr, rd_en, iss_valid, iss_dest, wb_en, wb_dest, wb_data, flush,
        input  rd_data, rd_pending, hazard, iss_ready, sb_busy
    );

    // Register file side
    modport slave (
        input  rd_addr, rd_en, iss_valid, iss_dest, wb_en, wb_dest, wb_data, flush,
        output rd_data, rd_pending, hazard, iss_ready, sb_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: RD_PORTS combinational read ports, one write-back
// port with same-cycle write-through bypass, and a per-register counter of
// outstanding writes that flags read-after-write hazards.
module regfile_scoreboard #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 15,
    parameter int ADDR_W    = 4,
    parameter int RD_PORTS  = 2,
    parameter int CNT_W     = 2,
    parameter int INIT_MODE = 1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    // Extra bit so the bound still compares correctly when NUM_REGS == 2**ADDR_W
    localparam logic [ADDR_W:0]  NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];

    logic iss_ok;
    logic wb_ok;
    logic wb_hit;
    logic iss_ready_int;
    logic iss_fire;

    // Address range checks and issue/write-back qualification
    always_comb begin
        iss_ok        = ({1'b0, bus.iss_dest} < NUM_REGS_W);
        wb_ok         = ({1'b0, bus.wb_dest} < NUM_REGS_W);
        wb_hit        = bus.wb_en & wb_ok;
        iss_ready_int = iss_ok ? (cnt_q[bus.iss_dest] != CNT_MAX) : 1'b1;
        iss_fire      = bus.iss_valid & iss_ready_int & iss_ok;
    end

    assign bus.iss_ready = iss_ready_int;

    // Register contents: reset image, then write-back (flush does not block data)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
            end
        end else if (wb_hit) begin
            regs_q[bus.wb_dest] <= bus.wb_data;
        end
    end

    // Outstanding-write counters: flush wins, issue+wb to one register cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (!(iss_fire && wb_hit && (bus.iss_dest == bus.wb_dest))) begin
            if (iss_fire) begin
                cnt_q[bus.iss_dest] <= cnt_q[bus.iss_dest] + 1'b1;
            end
            if (wb_hit && (cnt_q[bus.wb_dest] != '0)) begin
                cnt_q[bus.wb_dest] <= cnt_q[bus.wb_dest] - 1'b1;
            end
        end
    end

    // Scoreboard busy reflects registered counter state only
    always_comb begin
        bus.sb_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.sb_busy = bus.sb_busy | (cnt_q[i] != '0);
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              addr_ok;
        logic              byp;
        logic [CNT_W-1:0]  cnt;
        logic              last_wb;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

        // Read port: bypass the in-flight write-back, unbacked addresses read 0.
        // A write-back retiring the last outstanding write clears pending,
        // because its data is already on the bypass path this cycle.
        always_comb begin
            addr_ok = ({1'b0, addr} < NUM_REGS_W);
            byp     = wb_hit & (bus.wb_dest == addr);
            cnt     = addr_ok ? cnt_q[addr] : '0;
            last_wb = byp & (cnt == CNT_W'(1)) & ~(iss_fire & (bus.iss_dest == addr));
            if (!addr_ok) begin
                bus.rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (byp) begin
                bus.rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
            end else begin
                bus.rd_data[k*DATA_W +: DATA_W] = regs_q[addr];
            end
            bus.rd_pending[k] = addr_ok & (cnt != '0) & ~last_wb;
        end
    end

    assign bus.hazard = |(bus.rd_en & bus.rd_pending);
endmodule
